// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, fetch entry type and default reset PC
package cpu_defs;

    localparam int          INSTR_W          = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with push/pop/flush and occupancy count
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - PC generator and fetch queue feeding decode, with redirect flush
module ifetch_queue
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              misalign_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic              r_misalign;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_rd_entry;

    assign w_pop  = out_valid & out_ready;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign w_push = fetch_en & ~redirect_valid & (~w_full | w_pop);

    assign w_wr_entry.pc    = r_pc;
    assign w_wr_entry.instr = imem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wr_entry),
        .o_rdata (w_rd_entry),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign imem_addr    = r_pc;
    assign out_valid    = (w_count != '0);
    assign out_instr    = w_rd_entry.instr;
    assign out_pc       = w_rd_entry.pc;
    assign misalign_err = r_misalign;

endmodule
